// File: rtl/mem_stage.sv
// Memory stage: unpacks the EX/MEM bus, drives the single-lane data memory,
// sequences vector loads/stores one lane per cycle and registers the MEM/WB results.
module mem_stage #(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int BW = 17 + 2 * M * N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BW-1:0]   bufferIn,
    input  logic [N-1:0]    memRdata,
    output logic [N-1:0]    memAddr,
    output logic [N-1:0]    memWdata,
    output logic            memWe,
    output logic            stall,
    output logic            wbRegWrite,
    output logic            wbMemToReg,
    output logic            wbModeSel,
    output logic [3:0]      wbRc,
    output logic [M*N-1:0]  wbAluResult,
    output logic [M*N-1:0]  wbReadData
);
    localparam int MN = M * N;
    localparam int LW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {IDLE, S_WAIT, V_LOAD, V_LAST, V_STORE} state_t;

    state_t state, next_state;
    logic [LW-1:0] lane, next_lane;
    logic [M-1:0][N-1:0] gather, rdata_c, rd3;
    logic [MN-1:0] alu;
    logic [N-1:0] base;
    logic [3:0] rc;
    logic mode_sel, mem_write, mem_to_reg, reg_write;
    logic is_vs, is_vl, is_sl, is_ss;
    logic we_c, stall_c;

    assign mode_sel   = bufferIn[2*MN+16];
    assign alu        = bufferIn[MN+10 +: MN];
    assign mem_write  = bufferIn[MN+6];
    assign mem_to_reg = bufferIn[MN+5];
    assign reg_write  = bufferIn[MN+4];
    assign rc         = bufferIn[MN +: 4];
    assign rd3        = bufferIn[MN-1:0];
    assign base       = alu[N-1:0];

    // memWrite wins over memToReg when both are set
    assign is_vs = mode_sel & mem_write;
    assign is_vl = mode_sel & mem_to_reg & ~mem_write;
    assign is_sl = ~mode_sel & mem_to_reg & ~mem_write;
    assign is_ss = ~mode_sel & mem_write;

    // lane is always 0 in IDLE, so scalar accesses use base and rd3 lane 0
    assign memAddr  = base + N'(lane);
    assign memWdata = rd3[lane];
    assign memWe    = we_c & rst;
    assign stall    = stall_c & rst;

    always_comb begin
        next_state = state;
        next_lane  = lane;
        we_c       = 1'b0;
        stall_c    = 1'b0;
        rdata_c    = '0;
        case (state)
            IDLE: begin
                if (is_vs) begin
                    we_c = 1'b1;
                    if (M > 1) begin
                        stall_c    = 1'b1;
                        next_state = V_STORE;
                        next_lane  = LW'(1);
                    end
                end else if (is_vl) begin
                    stall_c    = 1'b1;
                    next_state = (M > 1) ? V_LOAD : V_LAST;
                    next_lane  = (M > 1) ? LW'(1) : '0;
                end else if (is_sl) begin
                    stall_c    = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    we_c = is_ss;
                end
            end
            S_WAIT: begin
                rdata_c[0] = memRdata;
                next_state = IDLE;
            end
            V_LOAD: begin
                stall_c = 1'b1;
                if (lane == LW'(M - 1)) next_state = V_LAST;
                else                    next_lane  = lane + LW'(1);
            end
            V_LAST: begin
                rdata_c      = gather;
                rdata_c[M-1] = memRdata;
                next_state   = IDLE;
                next_lane    = '0;
            end
            V_STORE: begin
                we_c = 1'b1;
                if (lane == LW'(M - 1)) begin
                    next_state = IDLE;
                    next_lane  = '0;
                end else begin
                    stall_c   = 1'b1;
                    next_lane = lane + LW'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_lane  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            lane  <= '0;
        end else begin
            state <= next_state;
            lane  <= next_lane;
        end
    end

    // Data from the address driven in the previous cycle lands in lane-1
    always_ff @(posedge clk) begin
        if (!rst)                gather <= '0;
        else if (state == V_LOAD) gather[LW'(lane - LW'(1))] <= memRdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wbRegWrite  <= 1'b0;
            wbMemToReg  <= 1'b0;
            wbModeSel   <= 1'b0;
            wbRc        <= '0;
            wbAluResult <= '0;
            wbReadData  <= '0;
        end else if (stall_c) begin
            wbRegWrite <= 1'b0;
            wbMemToReg <= 1'b0;
        end else begin
            wbRegWrite  <= reg_write & ~is_vs;
            wbMemToReg  <= mem_to_reg & ~mem_write;
            wbModeSel   <= mode_sel;
            wbRc        <= rc;
            wbAluResult <= alu;
            wbReadData  <= rdata_c;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a registered-read memory model and
// hand-computed expectations checked by immediate assertions.
module tb_mem_stage;
    localparam int N  = 24;
    localparam int M  = 6;
    localparam int MN = M * N;
    localparam int BW = 17 + 2 * MN;

    logic clk = 1'b0;
    logic rst;
    logic [BW-1:0] bufferIn;
    logic [N-1:0] memRdata, memAddr, memWdata;
    logic memWe, stall, wbRegWrite, wbMemToReg, wbModeSel;
    logic [3:0] wbRc;
    logic [MN-1:0] wbAluResult, wbReadData;

    int tests = 0;
    int fails = 0;

    mem_stage #(.N(N), .M(M), .BW(BW)) dut (
        .clk(clk), .rst(rst), .bufferIn(bufferIn), .memRdata(memRdata),
        .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe), .stall(stall),
        .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg), .wbModeSel(wbModeSel),
        .wbRc(wbRc), .wbAluResult(wbAluResult), .wbReadData(wbReadData)
    );

    always #5 clk = ~clk;

    // Memory: 256 words indexed by the low address byte; unwritten words use a preset pattern
    logic [N-1:0] mem [256];
    bit           wr  [256];

    function automatic logic [N-1:0] init_val(input logic [N-1:0] a);
        if (a == 24'h10) return 24'hABCDEF;
        if (a >= 24'h20 && a < 24'h26) return a - 24'h1F;
        return '0;
    endfunction

    always @(posedge clk) begin
        if (memWe) begin
            mem[memAddr[7:0]] <= memWdata;
            wr[memAddr[7:0]]  <= 1'b1;
        end
        memRdata <= wr[memAddr[7:0]] ? mem[memAddr[7:0]] : init_val(memAddr);
    end

    function automatic logic [BW-1:0] mk(input logic ms, input logic [N-1:0] alu0,
                                         input logic mw, input logic mtr, input logic rw,
                                         input logic [3:0] rc, input logic [MN-1:0] rd3);
        logic [MN-1:0] alu;
        alu = '0;
        alu[N-1:0] = alu0;
        return {ms, 2'b00, 4'b0000, alu, 3'b000, mw, mtr, rw, rc, rd3};
    endfunction

    task automatic chk(input string tag, input logic [MN-1:0] obs, input logic [MN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [MN-1:0] vec;
    logic [M-1:0][N-1:0] lanes;

    initial begin
        rst = 1'b0;
        bufferIn = '0;
        tick();
        tick();
        // reset state, and outputs gated while a vector op sits on the bus under reset
        chk("rst_wb", {wbRegWrite, wbMemToReg, wbModeSel, wbRc, wbAluResult, wbReadData}, '0);
        bufferIn = mk(1, 24'h20, 0, 1, 1, 4'd1, '0);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_we", memWe, 0);
        tick();
        rst = 1'b1;

        // 1: scalar ALU op
        bufferIn = mk(0, 24'h000123, 0, 0, 1, 4'd5, '0);
        #1;
        chk("alu_stall", stall, 0);
        chk("alu_we", memWe, 0);
        tick();
        chk("alu_rw", wbRegWrite, 1);
        chk("alu_rc", wbRc, 5);
        chk("alu_res", wbAluResult[23:0], 24'h000123);
        chk("alu_rd", wbReadData, '0);

        // 2: scalar load from 0x10
        bufferIn = mk(0, 24'h10, 0, 1, 1, 4'd3, '0);
        #1;
        chk("sl_stall0", stall, 1);
        chk("sl_addr", memAddr, 24'h10);
        chk("sl_we", memWe, 0);
        tick();
        chk("sl_bubble_rw", wbRegWrite, 0);
        chk("sl_bubble_rc", wbRc, 5);
        chk("sl_stall1", stall, 0);
        tick();
        chk("sl_data", wbReadData, 144'hABCDEF);
        chk("sl_mtr", wbMemToReg, 1);
        chk("sl_rw", wbRegWrite, 1);
        chk("sl_rc", wbRc, 3);

        // 3: vector store with address wrap
        for (int i = 0; i < M; i++) lanes[i] = 24'h5A0000 | 24'(i + 1);
        bufferIn = mk(1, 24'hFFFFFE, 1, 0, 1, 4'd7, lanes);
        #1;
        for (int i = 0; i < M; i++) begin
            chk($sformatf("vs_we%0d", i), memWe, 1);
            chk($sformatf("vs_addr%0d", i), memAddr, 24'(24'hFFFFFE + i));
            chk($sformatf("vs_data%0d", i), memWdata, lanes[i]);
            chk($sformatf("vs_stall%0d", i), stall, (i < M - 1) ? 1 : 0);
            tick();
            if (i < M - 1) chk($sformatf("vs_bubble%0d", i), wbRegWrite, 0);
        end
        chk("vs_rw", wbRegWrite, 0);
        chk("vs_rc", wbRc, 7);
        chk("vs_mtr", wbMemToReg, 0);

        // 4: vector load from 0x20
        bufferIn = mk(1, 24'h20, 0, 1, 1, 4'd9, '0);
        #1;
        for (int c = 0; c <= M; c++) begin
            chk($sformatf("vl_stall%0d", c), stall, (c < M) ? 1 : 0);
            chk($sformatf("vl_we%0d", c), memWe, 0);
            if (c < M) chk($sformatf("vl_addr%0d", c), memAddr, 24'(24'h20 + c));
            tick();
            chk($sformatf("vl_rw%0d", c), wbRegWrite, (c == M) ? 1 : 0);
        end
        for (int i = 0; i < M; i++) lanes[i] = 24'(i + 1);
        vec = lanes;
        chk("vl_data", wbReadData, vec);
        chk("vl_mtr", wbMemToReg, 1);
        chk("vl_mode", wbModeSel, 1);
        chk("vl_rc", wbRc, 9);
        bufferIn = mk(0, 24'h0, 0, 0, 0, 4'd0, '0);
        tick();
        chk("vl_rw_once", wbRegWrite, 0);

        // 5: reset during cycle 3 of a vector load
        bufferIn = mk(1, 24'h20, 0, 1, 1, 4'd2, '0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ab_stall", stall, 0);
        chk("ab_we", memWe, 0);
        tick();
        chk("ab_wb", {wbRegWrite, wbMemToReg, wbModeSel, wbRc, wbAluResult, wbReadData}, '0);
        rst = 1'b1;
        bufferIn = mk(0, 24'h0, 0, 0, 0, 4'd0, '0);
        #1;
        chk("ab_idle_stall", stall, 0);
        chk("ab_idle_we", memWe, 0);
        tick();

        // 6: vector store to 0x40, then scalar load from 0x43
        for (int i = 0; i < M; i++) lanes[i] = 24'hC00000 | 24'(i);
        bufferIn = mk(1, 24'h40, 1, 0, 0, 4'd4, lanes);
        for (int i = 0; i < M; i++) begin
            #1;
            chk($sformatf("bb_addr%0d", i), memAddr, 24'(24'h40 + i));
            chk($sformatf("bb_data%0d", i), memWdata, lanes[i]);
            tick();
        end
        chk("bb_vs_rc", wbRc, 4);
        bufferIn = mk(0, 24'h43, 0, 1, 1, 4'd6, '0);
        #1;
        chk("bb_ld_addr", memAddr, 24'h43);
        chk("bb_ld_stall", stall, 1);
        tick();
        chk("bb_ld_stall1", stall, 0);
        tick();
        chk("bb_ld_data", wbReadData, 144'hC00003);
        chk("bb_ld_rc", wbRc, 6);

        // read back a store that landed past the address wrap
        bufferIn = mk(0, 24'h000001, 0, 1, 1, 4'd8, '0);
        tick();
        tick();
        chk("wrap_data", wbReadData, 144'h5A0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage between the EX/MEM buffer and the writeback stage.
- Unpacks the EX/MEM bus and drives the single-lane data memory.
- Sequences vector loads and stores one lane per cycle, stalling upstream while it does so.
- Registers results into the MEM/WB register.

Parameters:
N, 24, lane/scalar data width and memory address width
M, 6, vector lanes
BW, 17+2*M*N, EX/MEM bus width (305 at defaults)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
bufferIn  in  BW  EX/MEM bus, MSB first: modeSel[1], opType[2], opCode[4], aluResult[M*N], zeroFlag, negFlag, branchFlag, memWrite, memToReg, regWrite, Rc[4], rd3[M*N]
memRdata  in  N  data memory read data, valid the cycle after its address is driven
memAddr  out  N  data memory address (combinational)
memWdata  out  N  data memory write data (combinational)
memWe  out  1  data memory write enable (combinational)
stall  out  1  hold EX/MEM and earlier stages (EX/MEM en = ~stall)
wbRegWrite  out  1  registered
wbMemToReg  out  1  registered
wbModeSel  out  1  registered
wbRc  out  4  registered
wbAluResult  out  M*N  registered
wbReadData  out  M*N  registered; lane i at [i*N +: N]

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, lane=0, all wb* outputs=0.
  - stall=0, memWe=0 while rst=0.
- Addressing: word addressed; lane i address = aluResult[N-1:0]+i, mod 2^N (wraps).
- Store data: scalar = rd3[N-1:0]; vector lane i = rd3[i*N +: N].
- Op class, decoded from bus in IDLE:
  - modeSel=1 & memToReg=1 -> VLOAD
  - modeSel=1 & memWrite=1 -> VSTORE
  - modeSel=0 & memToReg=1 -> SLOAD
  - otherwise single-cycle (scalar store or no-memory op)
  - memWrite has priority over memToReg if both are set (memToReg ignored).
- Single-cycle ops:
  - stall=0.
  - Scalar store: memWe=1, memAddr=base, memWdata=rd3 lane 0.
  - At the next edge, wb* take the bus fields; wbReadData=0.
- SLOAD, 2 cycles:
  - C0 (IDLE): memAddr=base, stall=1; wb* written as bubble; go to S_WAIT.
  - C1 (S_WAIT): stall=0; at edge wbReadData[N-1:0]=memRdata, upper lanes 0, other wb* from bus; go to IDLE.
- VLOAD, M+1 cycles:
  - Cycles 0..M-1: memAddr=base+lane, stall=1.
  - Cycles 1..M: memRdata captured into lane-1 of an internal gather register.
  - Cycle M (V_LAST): stall=0; wb* written with the full gathered vector; go to IDLE.
- VSTORE, M cycles:
  - Cycle i: memWe=1, memAddr=base+i, memWdata=lane i.
  - stall=1 for cycles 0..M-2, stall=0 at cycle M-1.
  - At the end of cycle M-1, wb* take the bus fields with wbRegWrite forced 0.
- Bubble: in every cycle with stall=1, wbRegWrite=0 and wbMemToReg=0; all other wb* hold.
  - Each instruction is therefore presented to WB exactly once.
- Lane counter: 0..M-1, cleared on entry to and exit from VLOAD/VSTORE.
- Bus hold: bufferIn is stable while stall=1; the block samples it every cycle and does not latch it.
- Next instruction: the instruction after a multi-cycle op is accepted in the cycle after stall falls. Back-to-back vector ops have no dead cycle beyond this.
- Reset mid-operation:
  - Abort; state=IDLE; memWe=0 in the reset cycle.
  - Partial vector store writes already done remain in memory.
- memWe is never asserted for loads or no-memory ops.
- opType, opCode, zeroFlag, negFlag, branchFlag are not consumed; branch resolution is not done here.

Test Plan:
1. Scalar ALU op, aluResult lane0=0x000123, regWrite=1, Rc=5 -> stall never 1; next edge wbRegWrite=1, wbRc=5, wbAluResult[23:0]=0x000123, memWe=0.
2. Scalar load, base=0x10, memory[0x10]=0xABCDEF -> stall=1 for one cycle with bubble; then wbReadData[23:0]=0xABCDEF, upper lanes 0, wbMemToReg=1.
3. Vector store, base=0xFFFFFE, rd3 lanes 1..6 -> memWe on 6 consecutive cycles at addresses FFFFFE, FFFFFF, 0, 1, 2, 3 with matching data; stall high 5 cycles; wbRegWrite=0 afterwards.
4. Vector load, base=0x20, memory[0x20+i]=i+1 -> stall high 6 cycles; on cycle 7 wbReadData lanes = 1..6; wbRegWrite pulses once only.
5. rst=0 at cycle 3 of a vector load -> next cycle state IDLE, stall=0, all wb* = 0, no memWe.
6. Vector store immediately followed by scalar load -> load address appears the cycle after stall falls; total 6+2 cycles; both results correct.
